clock_time_counter: RTL and testbench

Time-of-day counter for the digital clock. Consumes the 1 Hz `ENABLE` tick and the `ENABLE_kHz` sampling strobe from the one-second divider; produces BCD hours/minutes/seconds for the display stage. Also debounces the two user buttons and runs a small set-mode state machine for adjusting hours and minutes.

---
 rtl/clock_pkg.sv | 35 +++
 rtl/btn_debounce.sv | 60 ++++++
 rtl/clock_time_counter.sv | 142 ++++++++++++++
 tb/tb_clock_time_counter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and limits for the time-of-day counter.
// State encodings, BCD digit limits and the BCD increment helper.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10
  } state_e;

  localparam logic [2:0] SEC_MAX_T       = 3'd5;
  localparam logic [2:0] MIN_MAX_T       = 3'd5;
  localparam logic [1:0] HOUR_MAX_T      = 2'd2;
  localparam logic [3:0] HOUR_MAX_O_AT_2 = 4'd3;
  localparam logic [3:0] DIG_MAX_O       = 4'd9;

  localparam int DEB_SAMPLES_DEF = 256;

  // Mod-60 BCD increment of a {tens, ones} pair.
  function automatic logic [6:0] inc_60(
    input logic [2:0] t,
    input logic [3:0] o
  );
    logic [2:0] nt;
    logic [3:0] no;
    nt = t;
    no = o + 4'd1;
    if (o == DIG_MAX_O) begin
      no = 4'd0;
      nt = (t == SEC_MAX_T) ? 3'd0 : t + 3'd1;
    end
    return {nt, no};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, strobe-sampled debounce.
// Ports: CLK, RESET, ENABLE_kHz, BTN_RAW in; LEVEL, PRESS (0->1 pulse) out.
module btn_debounce
  import clock_pkg::*;
#(
  parameter int DEB_SAMPLES = DEB_SAMPLES_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ENABLE_kHz,
  input  logic BTN_RAW,
  output logic LEVEL,
  output logic PRESS
);

  localparam int CW = $clog2(DEB_SAMPLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_SAMPLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (ENABLE_kHz) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= BTN_RAW;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign LEVEL = level_q;
  assign PRESS = press_q;

endmodule

// File: rtl/clock_time_counter.sv
// Time-of-day BCD counter with debounced MODE/UP set-mode control.
// In: CLK, RESET, ENABLE, ENABLE_kHz, BTN_MODE, BTN_UP; out: BCD digits, MODE, DAY_TICK.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int DEB_SAMPLES = DEB_SAMPLES_DEF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       ENABLE_kHz,
  input  logic       BTN_MODE,
  input  logic       BTN_UP,
  output logic [1:0] HOUR_T,
  output logic [3:0] HOUR_O,
  output logic [2:0] MIN_T,
  output logic [3:0] MIN_O,
  output logic [2:0] SEC_T,
  output logic [3:0] SEC_O,
  output logic [1:0] MODE,
  output logic       DAY_TICK
);

  logic mode_press, up_press;
  logic mode_level, up_level;
  logic unused_levels;

  btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_mode (
    .CLK(CLK), .RESET(RESET), .ENABLE_kHz(ENABLE_kHz),
    .BTN_RAW(BTN_MODE), .LEVEL(mode_level), .PRESS(mode_press)
  );

  btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_up (
    .CLK(CLK), .RESET(RESET), .ENABLE_kHz(ENABLE_kHz),
    .BTN_RAW(BTN_UP), .LEVEL(up_level), .PRESS(up_press)
  );

  assign unused_levels = mode_level ^ up_level;

  state_e     state_q, state_d;
  logic [1:0] hour_t_q, hour_t_d;
  logic [3:0] hour_o_q, hour_o_d;
  logic [2:0] min_t_q, min_t_d;
  logic [3:0] min_o_q, min_o_d;
  logic [2:0] sec_t_q, sec_t_d;
  logic [3:0] sec_o_q, sec_o_d;
  logic       day_tick_q, day_tick_d;

  logic sec_wrap, min_wrap, hour_wrap;
  logic inc_sec, inc_min, inc_hour;

  assign sec_wrap  = (sec_t_q == SEC_MAX_T) && (sec_o_q == DIG_MAX_O);
  assign min_wrap  = (min_t_q == MIN_MAX_T) && (min_o_q == DIG_MAX_O);
  assign hour_wrap = (hour_t_q == HOUR_MAX_T) && (hour_o_q == HOUR_MAX_O_AT_2);

  always_comb begin
    state_d    = state_q;
    hour_t_d   = hour_t_q;
    hour_o_d   = hour_o_q;
    min_t_d    = min_t_q;
    min_o_d    = min_o_q;
    sec_t_d    = sec_t_q;
    sec_o_d    = sec_o_q;
    day_tick_d = 1'b0;
    inc_sec    = 1'b0;
    inc_min    = 1'b0;
    inc_hour   = 1'b0;

    // A MODE press swallows any same-cycle tick or UP press.
    if (mode_press) begin
      unique case (state_q)
        ST_RUN: begin
          state_d = ST_SET_HOUR;
          sec_t_d = '0;
          sec_o_d = '0;
        end
        ST_SET_HOUR: state_d = ST_SET_MIN;
        default:     state_d = ST_RUN;
      endcase
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (ENABLE) begin
            inc_sec    = 1'b1;
            inc_min    = sec_wrap;
            inc_hour   = sec_wrap && min_wrap;
            day_tick_d = sec_wrap && min_wrap && hour_wrap;
          end
        end
        ST_SET_HOUR: inc_hour = up_press;
        ST_SET_MIN:  inc_min  = up_press;
        default: ;
      endcase
    end

    if (inc_sec) {sec_t_d, sec_o_d} = inc_60(sec_t_q, sec_o_q);
    if (inc_min) {min_t_d, min_o_d} = inc_60(min_t_q, min_o_q);
    if (inc_hour) begin
      if (hour_wrap) begin
        hour_t_d = '0;
        hour_o_d = '0;
      end else if (hour_o_q == DIG_MAX_O) begin
        hour_t_d = hour_t_q + 2'd1;
        hour_o_d = '0;
      end else begin
        hour_o_d = hour_o_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_RUN;
      hour_t_q   <= '0;
      hour_o_q   <= '0;
      min_t_q    <= '0;
      min_o_q    <= '0;
      sec_t_q    <= '0;
      sec_o_q    <= '0;
      day_tick_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hour_t_q   <= hour_t_d;
      hour_o_q   <= hour_o_d;
      min_t_q    <= min_t_d;
      min_o_q    <= min_o_d;
      sec_t_q    <= sec_t_d;
      sec_o_q    <= sec_o_d;
      day_tick_q <= day_tick_d;
    end
  end

  assign HOUR_T   = hour_t_q;
  assign HOUR_O   = hour_o_q;
  assign MIN_T    = min_t_q;
  assign MIN_O    = min_o_q;
  assign SEC_T    = sec_t_q;
  assign SEC_O    = sec_o_q;
  assign MODE     = state_q;
  assign DAY_TICK = day_tick_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Bench for clock_time_counter: directed scenarios plus random ops
// against an integer h/m/s reference model.
module tb_clock_time_counter;

  localparam int DEB = 4;

  logic       CLK = 1'b0;
  logic       RESET, ENABLE, ENABLE_kHz, BTN_MODE, BTN_UP;
  logic [1:0] HOUR_T;
  logic [3:0] HOUR_O;
  logic [2:0] MIN_T;
  logic [3:0] MIN_O;
  logic [2:0] SEC_T;
  logic [3:0] SEC_O;
  logic [1:0] MODE;
  logic       DAY_TICK;

  int checks = 0;
  int errors = 0;
  int h, m, s, mode;

  always #4 CLK = ~CLK;

  clock_time_counter #(.DEB_SAMPLES(DEB)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .ENABLE_kHz(ENABLE_kHz),
    .BTN_MODE(BTN_MODE), .BTN_UP(BTN_UP),
    .HOUR_T(HOUR_T), .HOUR_O(HOUR_O), .MIN_T(MIN_T), .MIN_O(MIN_O),
    .SEC_T(SEC_T), .SEC_O(SEC_O), .MODE(MODE), .DAY_TICK(DAY_TICK)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " hour_t"}, 32'(HOUR_T), h / 10);
    check({tag, " hour_o"}, 32'(HOUR_O), h % 10);
    check({tag, " min_t"}, 32'(MIN_T), m / 10);
    check({tag, " min_o"}, 32'(MIN_O), m % 10);
    check({tag, " sec_t"}, 32'(SEC_T), s / 10);
    check({tag, " sec_o"}, 32'(SEC_O), s % 10);
    check({tag, " mode"}, 32'(MODE), mode);
  endtask

  task automatic strobe();
    ENABLE_kHz = 1'b1;
    @(negedge CLK);
    ENABLE_kHz = 1'b0;
    @(negedge CLK);
  endtask

  task automatic do_tick(input string tag);
    bit dt;
    dt = 1'b0;
    ENABLE = 1'b1;
    @(negedge CLK);
    ENABLE = 1'b0;
    if (mode == 0) begin
      s++;
      if (s == 60) begin s = 0; m++; end
      if (m == 60) begin m = 0; h++; end
      if (h == 24) begin h = 0; dt = 1'b1; end
    end
    check({tag, " day"}, 32'(DAY_TICK), 32'(dt));
    check_all(tag);
    @(negedge CLK);
    check({tag, " day_off"}, 32'(DAY_TICK), 0);
  endtask

  // Full press/release of one or both buttons; optional ENABLE aligned
  // with the press pulse and extra strobes while held.
  task automatic press(input string tag, input bit mb, input bit ub,
                       input bit with_tick, input int extra);
    BTN_MODE = mb;
    BTN_UP   = ub;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < DEB; i++) begin
      ENABLE_kHz = 1'b1;
      @(negedge CLK);
      ENABLE_kHz = 1'b0;
      if (i == DEB - 1) ENABLE = with_tick;
      @(negedge CLK);
      ENABLE = 1'b0;
    end
    if (mb) begin
      if (mode == 0) s = 0;
      mode = (mode + 1) % 3;
    end else if (ub) begin
      if (mode == 1) h = (h + 1) % 24;
      else if (mode == 2) m = (m + 1) % 60;
    end
    check({tag, " day"}, 32'(DAY_TICK), 0);
    check_all(tag);
    for (int i = 0; i < extra; i++) strobe();
    if (extra > 0) check_all({tag, " held"});
    BTN_MODE = 1'b0;
    BTN_UP   = 1'b0;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < DEB; i++) strobe();
    check_all({tag, " rel"});
  endtask

  task automatic set_time(input int hh, input int mm);
    press("set_enter", 1, 0, 0, 0);
    while (h != hh) press("set_h", 0, 1, 0, 0);
    press("set_mode", 1, 0, 0, 0);
    while (m != mm) press("set_m", 0, 1, 0, 0);
  endtask

  initial begin
    RESET = 1'b1; ENABLE = 1'b0; ENABLE_kHz = 1'b0;
    BTN_MODE = 1'b0; BTN_UP = 1'b0;
    h = 0; m = 0; s = 0; mode = 0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    check_all("reset");
    check("reset day", 32'(DAY_TICK), 0);

    for (int i = 0; i < 60; i++) do_tick("run");

    BTN_MODE = 1'b1;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < DEB - 1; i++) strobe();
    BTN_MODE = 1'b0;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 2; i++) strobe();
    check_all("glitch");

    for (int i = 0; i < 5; i++) do_tick("pre_set");
    press("mode_held", 1, 0, 0, 3);
    do_tick("frozen_h");
    while (h != 23) press("up_h", 0, 1, 0, 0);
    press("up_h_wrap", 0, 1, 0, 0);
    check("hour wrap", 32'(h), 0);
    press("to_min", 1, 0, 0, 0);
    for (int i = 0; i < 61; i++) press("up_m", 0, 1, 0, 0);
    do_tick("frozen_m");
    press("to_run", 1, 0, 0, 0);

    set_time(23, 59);
    press("run_again", 1, 0, 0, 0);
    for (int i = 0; i < 58; i++) do_tick("to_58");
    do_tick("at_59");
    do_tick("rollover");

    for (int i = 0; i < 10; i++) do_tick("to_10");
    press("mode_tick", 1, 0, 1, 0);
    press("both", 1, 1, 0, 0);
    press("back_run", 1, 0, 0, 0);

    for (int n = 0; n < 200; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) do_tick("rnd_tick");
      else if (r == 6) press("rnd_mode", 1, 0, 0, 0);
      else if (r < 9) press("rnd_up", 0, 1, 0, 0);
      else press("rnd_mode_tick", 1, 0, 1, 0);
    end

    while (mode != 0) press("home", 1, 0, 0, 0);
    set_time(12, 34);
    BTN_MODE = 1'b1;
    RESET = 1'b1;
    @(negedge CLK);
    h = 0; m = 0; s = 0; mode = 0;
    check_all("rst_mid");
    check("rst_mid day", 32'(DAY_TICK), 0);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < DEB - 1; i++) strobe();
    check_all("held_rst_short");
    strobe();
    @(negedge CLK);
    mode = 1;
    check_all("held_rst_full");
    BTN_MODE = 1'b0;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < DEB; i++) strobe();
    check_all("held_rst_rel");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
